// File: rtl/demux_collector_pkg.sv
// Shared types and constants for the demux word collector.
package demux_collector_pkg;

   localparam int unsigned NUM_CH   = 4;
   localparam int unsigned CH_W     = 2;
   localparam int unsigned OVFCNT_W = 16;

   // Channel index, also the width of the demux select
   typedef logic [CH_W-1:0] chan_t;

   // Output stage: nothing presented / word held on the output stream
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } out_state_t;

   // Round-robin successor of a channel, wrapping at NUM_CH
   function automatic chan_t next_chan(input chan_t c);
      return c + chan_t'(1);
   endfunction

endpackage

// File: rtl/demux_chan_shifter.sv
// One demux channel: bit shift register, bit counter, holding word,
// full flag and sticky overflow detection.
// Optional: DEMUX_COLLECTOR_OVFCNT_EN exposes a per-cycle drop strobe.
module demux_chan_shifter #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap,
   input  logic              bit_in,
   input  logic              drain,
   output logic [DATA_W-1:0] hold,
   output logic              full,
   output logic              ovf
`ifdef DEMUX_COLLECTOR_OVFCNT_EN
   ,
   output logic              ovf_evt_c
`endif
);

   localparam int unsigned       CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] sr_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              last_c;
   logic              drop_c;

   // Next shift-register value including the incoming bit; completion and drop decode
   always_comb begin
      sr_d = sr_q;
      if (MSB_FIRST) begin
         sr_d = {sr_q[DATA_W-2:0], bit_in};
      end else begin
         sr_d = {bit_in, sr_q[DATA_W-1:1]};
      end
      last_c = cap && (cnt_q == CNT_LAST);
      // A completing word is lost only if the previous one is still held and not leaving now
      drop_c = last_c && full && !drain;
   end

`ifdef DEMUX_COLLECTOR_OVFCNT_EN
   assign ovf_evt_c = drop_c;
`endif

   // Bit accumulation; runs regardless of whether the completed word is kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (cap) begin
         sr_q <= sr_d;
         if (last_c) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Holding word and full flag; a drain in the completion cycle frees the slot first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
         full <= 1'b0;
      end else if (last_c && !drop_c) begin
         hold <= sr_d;
         full <= 1'b1;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

   // Sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (drop_c) begin
         ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/demux_word_collector.sv
// Collects demultiplexed bits into per-channel words and merges the
// completed words onto one valid/ready stream with round-robin arbitration.
// Optional: DEMUX_COLLECTOR_OVFCNT_EN adds the saturating OvfCount output.
module demux_word_collector
   import demux_collector_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              BitValid,
   input  logic [CH_W-1:0]   Sel,
   input  logic [NUM_CH-1:0] DemuxOut,
   output logic [DATA_W-1:0] WordData,
   output logic [CH_W-1:0]   WordChan,
   output logic              WordValid,
   input  logic              WordReady,
   output logic [NUM_CH-1:0] Overflow,
   output logic              SelError
`ifdef DEMUX_COLLECTOR_OVFCNT_EN
   ,
   output logic [OVFCNT_W-1:0] OvfCount
`endif
);

   logic [DATA_W-1:0] hold [NUM_CH];
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] drain_c;
   logic              bit_c;

   out_state_t        state_q;
   out_state_t        state_d;
   chan_t             rr_q;
   chan_t             rr_d;
   logic [DATA_W-1:0] data_d;
   chan_t             chan_d;
   logic              valid_d;
   logic              sel_err_d;
   chan_t             idx;
   chan_t             pick;
   logic              found;

`ifdef DEMUX_COLLECTOR_OVFCNT_EN
   logic [NUM_CH-1:0] ovf_evt_c;
`endif

   // The data bit always comes from the selected demux output
   assign bit_c = DemuxOut[Sel];

   // Per-channel word assembly
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      demux_chan_shifter #(
         .DATA_W    (DATA_W),
         .MSB_FIRST (MSB_FIRST)
      ) u_shifter (
         .clk       (Clk),
         .rst_n     (Rst_n),
         .cap       (BitValid && (Sel == chan_t'(c))),
         .bit_in    (bit_c),
         .drain     (drain_c[c]),
         .hold      (hold[c]),
         .full      (full[c]),
         .ovf       (Overflow[c])
`ifdef DEMUX_COLLECTOR_OVFCNT_EN
         ,
         .ovf_evt_c (ovf_evt_c[c])
`endif
      );
   end

   // Round-robin scan: first full channel at or above the RR pointer, wrapping
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      idx   = rr_q;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = rr_q + chan_t'(i);
         if (!found && full[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Output FSM next state, output register inputs and drain strobes
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      data_d    = WordData;
      chan_d    = WordChan;
      valid_d   = WordValid;
      drain_c   = '0;
      sel_err_d = BitValid && ((DemuxOut & ~(NUM_CH'(1) << Sel)) != '0);
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               data_d  = hold[pick];
               chan_d  = pick;
               valid_d = 1'b1;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (WordReady) begin
               drain_c[WordChan] = 1'b1;
               valid_d           = 1'b0;
               rr_d              = next_chan(WordChan);
               state_d           = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output FSM state and registered outputs
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= ST_IDLE;
         rr_q      <= '0;
         WordData  <= '0;
         WordChan  <= '0;
         WordValid <= 1'b0;
         SelError  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         WordData  <= data_d;
         WordChan  <= chan_d;
         WordValid <= valid_d;
         SelError  <= sel_err_d;
      end
   end

`ifdef DEMUX_COLLECTOR_OVFCNT_EN
   // Saturating count of dropped words; at most one channel can drop per cycle
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         OvfCount <= '0;
      end else if ((ovf_evt_c != '0) && (OvfCount != '1)) begin
         OvfCount <= OvfCount + OVFCNT_W'(1);
      end
   end
`endif

endmodule
